// File: rtl/apb_pkg.sv
// Shared defaults, FSM state type and ID constant for the APB byte-memory completer.
package apb_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 9;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned CNT_WIDTH      = 4;
  localparam logic [7:0]  ID_CONST       = 8'hA5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// Byte storage: sync-reset array with one write port (enable) and one combinational read port.
module apb_slave_regfile #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned IDX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a small byte memory; address 0 is a read-only ID register.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(WAIT_CYCLES);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  done_c;
  logic                  in_range_c;
  logic                  err_c;
  logic                  we_c;
  logic [DATA_WIDTH-1:0] rf_rdata;

  // Next-state: accept setup in IDLE, count wait states, abort on a dropped handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_IDLE;
        end else if (!psel || !penable) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  // Response decode uses only the latched transfer; reset forces a quiet bus.
  always_comb begin
    in_range_c = 32'(addr_q) < 32'(DEPTH);
    err_c      = !in_range_c || (write_q && (addr_q == '0));
    done_c     = (state_q == ST_ACCESS) && (cnt_q == WAIT_LAST) && !preset;
    we_c       = done_c && write_q && !err_c;
    pready     = done_c;
    pslverr    = done_c && err_c;
    prdata     = '0;
    if (done_c && !write_q && in_range_c) begin
      prdata = (addr_q == '0) ? DATA_WIDTH'(ID_CONST) : rf_rdata;
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_regfile (
    .clk   (pclk),
    .rst   (preset),
    .we    (we_c),
    .waddr (addr_q[IDX_WIDTH-1:0]),
    .wdata (wdata_q),
    .raddr (addr_q[IDX_WIDTH-1:0]),
    .rdata (rf_rdata)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: directed table, random traffic vs. a memory model, abort corners.
module tb_apb_slave_mem;

  localparam int DEPTH = 64;
  localparam int WAITS = 1;

  logic       pclk;
  logic       preset;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [8:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int checks;
  int errors;

  logic [7:0] model_mem [DEPTH];

  typedef struct {
    bit         wr;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  apb_slave_mem #(
    .ADDR_WIDTH  (9),
    .DATA_WIDTH  (8),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAITS)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response of one completed transfer, applied to the model memory.
  task automatic model_xfer(input bit wr, input logic [8:0] addr, input logic [7:0] data,
                            output logic [7:0] exp_rdata, output bit exp_err);
    int a;
    a = int'(addr);
    exp_err   = (a >= DEPTH) || (wr && a == 0);
    exp_rdata = 8'h00;
    if (!wr && !exp_err) exp_rdata = (a == 0) ? 8'hA5 : model_mem[a];
    if (wr && !exp_err) model_mem[a] = data;
  endtask

  // Full APB transfer starting just after a rising edge; returns just after the edge ending pready.
  task automatic do_xfer(input bit wr, input logic [8:0] addr, input logic [7:0] data,
                         output logic [7:0] rdata, output bit err);
    int n;
    bit seen;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge pclk);
    chk("setup_pready", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = 9'($urandom);
    pwdata  = 8'($urandom);
    pwrite  = 1'($urandom);
    seen = 1'b0;
    rdata = 8'h00;
    err = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge pclk);
      if (pready === 1'b1) begin
        seen  = 1'b1;
        rdata = prdata;
        err   = pslverr;
        break;
      end
      chk("wait_pslverr", 32'(pslverr), 32'd0);
      chk("wait_prdata", 32'(prdata), 32'd0);
      @(posedge pclk); #1;
    end
    chk("pready_seen", 32'(seen), 32'd1);
    if (seen) chk("pready_latency", 32'(n), 32'(WAITS + 1));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  vec_t vecs [9];

  initial begin
    logic [7:0] rd;
    logic [7:0] exp_rd;
    bit         er;
    bit         exp_er;
    checks = 0;
    errors = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

    vecs[0] = '{1'b1, 9'h005, 8'h3C, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 9'h005, 8'h00, 8'h3C, 1'b0};
    vecs[2] = '{1'b1, 9'h040, 8'h99, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 9'h040, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 9'h000, 8'hFF, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 9'h000, 8'h00, 8'hA5, 1'b0};
    vecs[6] = '{1'b1, 9'h001, 8'h11, 8'h00, 1'b0};
    vecs[7] = '{1'b0, 9'h001, 8'h00, 8'h11, 1'b0};
    vecs[8] = '{1'b0, 9'h005, 8'h00, 8'h3C, 1'b0};

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", 32'(prdata), 32'd0);
    @(posedge pclk); #1;
    preset = 1'b0;
    @(negedge pclk);
    chk("idle_pready", 32'(pready), 32'd0);
    @(posedge pclk); #1;

    // Directed table, issued back to back.
    for (int i = 0; i < 9; i++) begin
      do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
      model_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, exp_rd, exp_er);
      chk($sformatf("vec%0d_prdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Reset during the first ACCESS cycle aborts the write and clears memory.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h002; pwdata = 8'h77;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(negedge pclk);
    chk("rstabort_pready", 32'(pready), 32'd0);
    chk("rstabort_prdata", 32'(prdata), 32'd0);
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    repeat (2) begin
      @(negedge pclk);
      chk("rstabort_after_pready", 32'(pready), 32'd0);
      @(posedge pclk); #1;
    end
    do_xfer(1'b0, 9'h002, 8'h00, rd, er);
    chk("rstabort_read2", 32'(rd), 32'h00);
    chk("rstabort_read2_err", 32'(er), 32'd0);

    // penable dropped in the first ACCESS cycle aborts the write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h003; pwdata = 8'h55;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("penabort_pready", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      chk("penabort_after_pready", 32'(pready), 32'd0);
      @(posedge pclk); #1;
    end
    do_xfer(1'b0, 9'h003, 8'h00, rd, er);
    chk("penabort_read3", 32'(rd), 32'h00);

    // Random traffic against the model, including ID and out-of-range addresses.
    for (int i = 0; i < 60; i++) begin
      bit         wr;
      logic [8:0] a;
      logic [7:0] d;
      wr = 1'($urandom);
      a  = 9'($urandom_range(0, 79));
      if (($urandom % 8) == 0) a = 9'($urandom_range(DEPTH, 511));
      d  = 8'($urandom);
      do_xfer(wr, a, d, rd, er);
      model_xfer(wr, a, d, exp_rd, exp_er);
      chk($sformatf("rnd%0d_prdata", i), 32'(rd), 32'(exp_rd));
      chk($sformatf("rnd%0d_pslverr", i), 32'(er), 32'(exp_er));
    end

    // Final sweep of every location.
    for (int a = 0; a < DEPTH; a++) begin
      do_xfer(1'b0, 9'(a), 8'h00, rd, er);
      model_xfer(1'b0, 9'(a), 8'h00, exp_rd, exp_er);
      chk($sformatf("sweep%0d", a), 32'(rd), 32'(exp_rd));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, paddr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, pwdata/prdata width.
REQ-003 SHALL have parameter DEPTH, default 64, number of implemented byte locations (0..DEPTH-1).
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before pready (0..15).
REQ-005 SHALL use one clock and a synchronous, active-high reset:
- pclk  in  1  clock; all state updates on rising edge.
- preset  in  1  synchronous active-high reset.
- psel  in  1  completer select.
- penable  in  1  access phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data, valid only with pready on a read.
- pready  out  1  transfer completion.
- pslverr  out  1  transfer error, valid only with pready.

Function
REQ-006 SHALL implement FSM states IDLE and ACCESS with a 4-bit wait counter cnt.
REQ-007 IDLE: psel=1 and penable=0 (setup) SHALL latch paddr, pwrite, pwdata, set cnt=0, go to ACCESS; all other input combinations SHALL be ignored.
REQ-008 ACCESS: cnt SHALL increment each cycle while cnt < WAIT_CYCLES.
REQ-009 pready SHALL be 1 exactly in the ACCESS cycle where cnt == WAIT_CYCLES; first ACCESS cycle follows setup, so pready is asserted WAIT_CYCLES+1 cycles after the setup cycle.
REQ-010 pready, pslverr, prdata SHALL be decoded only from registered state, counter and latched transfer (no input-to-output combinational path).
REQ-011 Error condition: latched address >= DEPTH, or write to address 0.
REQ-012 pslverr SHALL equal the error condition when pready=1, else 0.
REQ-013 Write without error SHALL update memory at the clock edge ending the pready cycle; errored writes SHALL leave memory unchanged.
REQ-014 Address 0 SHALL be read-only and SHALL read constant ID 0xA5.
REQ-015 prdata SHALL be memory[addr] on an in-range read with pready=1; otherwise (write, out-of-range read, pready=0) prdata SHALL be 0.
REQ-016 After the pready cycle FSM SHALL return to IDLE; next setup is accepted in the following cycle (back-to-back transfers, no extra dead cycle).
REQ-017 In ACCESS before pready, psel=0 or penable=0 SHALL abort: go to IDLE, no memory update, no pready.
REQ-018 Latched pwdata/paddr SHALL be used throughout ACCESS; input changes during ACCESS SHALL have no effect.

Reset
REQ-019 preset=1 SHALL force state IDLE, cnt=0, all memory locations 1..DEPTH-1 to 0 at the next edge; pready=0, pslverr=0, prdata=0 while in reset.
REQ-020 Reset during ACCESS SHALL abort the transfer with no memory update and no pready.

Structure
REQ-021 Shared package apb_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults, the FSM state enum typedef and the ID constant 0xA5.
REQ-022 Memory array SHALL be a sub-module apb_slave_regfile (sync reset, single write port with enable, combinational read port).

Verification (WAIT_CYCLES=1, DEPTH=64)
REQ-023 Write 0x3C @0x005, then read @0x005 -> pready in 2nd ACCESS cycle each, read prdata=0x3C, pslverr=0.
REQ-024 Write 0x99 @0x040 and read @0x040 -> pslverr=1 with pready both times, read prdata=0x00, no location changed.
REQ-025 Write 0xFF @0x000 -> pslverr=1; subsequent read @0x000 -> prdata=0xA5, pslverr=0.
REQ-026 Back-to-back write 0x11 @0x001 then read @0x001 (setup immediately after pready) -> prdata=0x11, no missed transfer.
REQ-027 Write 0x77 @0x002, preset=1 in first ACCESS cycle -> no pready; read @0x002 after reset -> 0x00.
REQ-028 Write 0x55 @0x003, penable dropped in first ACCESS cycle -> no pready, read @0x003 -> 0x00.
